// File: rtl/unibus_pwrseq.sv
// Unibus power sequencer: orders BUS DC LO, INIT and AC LO on power-up, power-down and CPU RESET.
// Define PWRSEQ_SYNC_EN to pass pwr_req and cpu_reset_req through 2-flop synchronizers.
module unibus_pwrseq #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned OFF_MIN  = 'o1000,
  parameter int unsigned DC_DLY   = 'o2000,
  parameter int unsigned INIT_LEN = 'o400,
  parameter int unsigned AC_DLY   = 'o2000,
  parameter int unsigned PF_DLY   = 'o4000
) (
  input  logic clk,
  input  logic reset,
  input  logic pwr_req,
  input  logic cpu_reset_req,
  output logic bus_ac_lo,
  output logic bus_dc_lo,
  output logic bus_init,
  output logic pwr_ok
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DCUP,
    S_INIT,
    S_ACUP,
    S_RUN,
    S_SWINIT,
    S_PFAIL
  } state_t;

  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_MIN - 1);
  localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DC_DLY - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_LEN - 1);
  localparam logic [CNT_W-1:0] AC_LAST   = CNT_W'(AC_DLY - 1);
  localparam logic [CNT_W-1:0] PF_LAST   = CNT_W'(PF_DLY - 1);

  logic pwr_on;
  logic sw_reset;

`ifdef PWRSEQ_SYNC_EN
  logic [1:0] pwr_sync;
  logic [1:0] rst_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwr_sync <= '0;
      rst_sync <= '0;
    end else begin
      pwr_sync <= {pwr_sync[0], pwr_req};
      rst_sync <= {rst_sync[0], cpu_reset_req};
    end
  end

  assign pwr_on   = pwr_sync[1];
  assign sw_reset = rst_sync[1];
`else
  assign pwr_on   = pwr_req;
  assign sw_reset = cpu_reset_req;
`endif

  // Output vector order: {ac_lo, dc_lo, init, pwr_ok}
  function automatic logic [3:0] outs_of(input state_t s);
    logic [3:0] o;
    o = 4'b1110;
    unique case (s)
      S_OFF:    o = 4'b1110;
      S_DCUP:   o = 4'b1110;
      S_INIT:   o = 4'b1010;
      S_ACUP:   o = 4'b1000;
      S_RUN:    o = 4'b0001;
      S_SWINIT: o = 4'b0011;
      S_PFAIL:  o = 4'b1000;
      default:  o = 4'b1110;
    endcase
    return o;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       outs_q;

  assign {bus_ac_lo, bus_dc_lo, bus_init, pwr_ok} = outs_q;

  // Each transition clears cnt and loads the target state's outputs on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_OFF;
      cnt    <= '0;
      outs_q <= outs_of(S_OFF);
    end else begin
      cnt <= cnt + CNT_W'(1);
      unique case (state)
        S_OFF: begin
          if (cnt == OFF_LAST) begin
            if (pwr_on) begin
              state  <= S_DCUP;
              cnt    <= '0;
              outs_q <= outs_of(S_DCUP);
            end else begin
              cnt <= cnt;
            end
          end
        end
        S_DCUP: begin
          if (!pwr_on) begin
            state  <= S_OFF;
            cnt    <= '0;
            outs_q <= outs_of(S_OFF);
          end else if (cnt == DC_LAST) begin
            state  <= S_INIT;
            cnt    <= '0;
            outs_q <= outs_of(S_INIT);
          end
        end
        S_INIT: begin
          if (!pwr_on) begin
            state  <= S_PFAIL;
            cnt    <= '0;
            outs_q <= outs_of(S_PFAIL);
          end else if (cnt == INIT_LAST) begin
            state  <= S_ACUP;
            cnt    <= '0;
            outs_q <= outs_of(S_ACUP);
          end
        end
        S_ACUP: begin
          if (!pwr_on) begin
            state  <= S_PFAIL;
            cnt    <= '0;
            outs_q <= outs_of(S_PFAIL);
          end else if (cnt == AC_LAST) begin
            state  <= S_RUN;
            cnt    <= '0;
            outs_q <= outs_of(S_RUN);
          end
        end
        S_RUN: begin
          cnt <= '0;
          if (!pwr_on) begin
            state  <= S_PFAIL;
            outs_q <= outs_of(S_PFAIL);
          end else if (sw_reset) begin
            state  <= S_SWINIT;
            outs_q <= outs_of(S_SWINIT);
          end
        end
        S_SWINIT: begin
          if (!pwr_on) begin
            state  <= S_PFAIL;
            cnt    <= '0;
            outs_q <= outs_of(S_PFAIL);
          end else if (sw_reset) begin
            cnt <= '0;
          end else if (cnt == INIT_LAST) begin
            state  <= S_RUN;
            cnt    <= '0;
            outs_q <= outs_of(S_RUN);
          end
        end
        S_PFAIL: begin
          if (cnt == PF_LAST) begin
            state  <= S_OFF;
            cnt    <= '0;
            outs_q <= outs_of(S_OFF);
          end
        end
        default: begin
          state  <= S_OFF;
          cnt    <= '0;
          outs_q <= outs_of(S_OFF);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unibus_pwrseq.sv
// Self-checking bench for unibus_pwrseq with small delays and a countdown reference model.
module tb_unibus_pwrseq;

  localparam int unsigned OFF_MIN  = 2;
  localparam int unsigned DC_DLY   = 4;
  localparam int unsigned INIT_LEN = 3;
  localparam int unsigned AC_DLY   = 5;
  localparam int unsigned PF_DLY   = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pwr_req = 1'b0;
  logic cpu_reset_req = 1'b0;
  logic bus_ac_lo, bus_dc_lo, bus_init, pwr_ok;

  unibus_pwrseq #(
    .CNT_W(8), .OFF_MIN(OFF_MIN), .DC_DLY(DC_DLY), .INIT_LEN(INIT_LEN),
    .AC_DLY(AC_DLY), .PF_DLY(PF_DLY)
  ) dut (
    .clk(clk), .reset(reset), .pwr_req(pwr_req), .cpu_reset_req(cpu_reset_req),
    .bus_ac_lo(bus_ac_lo), .bus_dc_lo(bus_dc_lo), .bus_init(bus_init), .pwr_ok(pwr_ok)
  );

  always #5 clk = ~clk;

  logic [3:0] obs;
  assign obs = {bus_ac_lo, bus_dc_lo, bus_init, pwr_ok};

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Reference model: phase index plus clocks left in the phase.
  localparam int P_OFF = 0, P_DCUP = 1, P_INIT = 2, P_ACUP = 3, P_RUN = 4, P_SWINIT = 5, P_PFAIL = 6;
  localparam logic [3:0] OUT_TAB [7] = '{4'b1110, 4'b1110, 4'b1010, 4'b1000, 4'b0001, 4'b0011, 4'b1000};
  localparam int NEXT_TAB [7] = '{P_DCUP, P_INIT, P_ACUP, P_RUN, P_RUN, P_RUN, P_OFF};
  localparam int DUR_TAB  [7] = '{OFF_MIN, DC_DLY, INIT_LEN, AC_DLY, 0, INIT_LEN, PF_DLY};

  int m_ph;
  int m_left;

  function automatic logic [3:0] m_out();
    return OUT_TAB[m_ph];
  endfunction

  task automatic m_goto(input int ph);
    m_ph   = ph;
    m_left = DUR_TAB[ph];
  endtask

  task automatic m_reset();
    m_goto(P_OFF);
  endtask

  task automatic m_step(input logic pr, input logic cr);
    if (!pr && m_ph == P_DCUP) m_goto(P_OFF);
    else if (!pr && m_ph inside {P_INIT, P_ACUP, P_RUN, P_SWINIT}) m_goto(P_PFAIL);
    else if (cr && m_ph inside {P_RUN, P_SWINIT}) m_goto(P_SWINIT);
    else if (m_ph == P_RUN) ;
    else if (m_left > 1) m_left--;
    else if (m_ph != P_OFF || pr) m_goto(NEXT_TAB[m_ph]);
  endtask

  task automatic tick(input logic pr, input logic cr);
    pwr_req = pr;
    cpu_reset_req = cr;
    @(posedge clk);
    m_step(pr, cr);
    edge_n++;
    #1;
  endtask

  task automatic do_reset(input logic pr);
    reset = 1'b0;
    pwr_req = pr;
    cpu_reset_req = 1'b0;
    @(negedge clk);
    m_reset();
    edge_n = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pwr_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b", obs, 4'b1110);
    end
    m_reset();
    edge_n = 0;
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (obs !== 4'b1110 || obs !== m_out()) begin
        n_fail++;
        $display("FAIL off_idle edge %0d: got %b expected %b", edge_n, obs, 4'b1110);
      end
    end
  endtask

  task automatic test_powerup();
    logic [3:0] exp;
    do_reset(1'b1);
    for (int e = 1; e <= 16; e++) begin
      tick(1'b1, 1'b0);
      exp = {e < 14, e < 6, e < 9, e >= 14};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL powerup_timeline edge %0d: got %b expected %b", edge_n, obs, exp);
      end
      n_checks++;
      if (obs !== m_out()) begin
        n_fail++;
        $display("FAIL powerup_model edge %0d: got %b expected %b", edge_n, obs, m_out());
      end
    end
  endtask

  task automatic test_swinit();
    for (int r = 1; r <= 5; r++) begin
      tick(1'b1, r == 1);
      n_checks++;
      if (bus_init !== (r <= 3) || obs !== m_out()) begin
        n_fail++;
        $display("FAIL swinit_single rel %0d: got %b expected %b", r, obs, m_out());
      end
    end
    for (int r = 1; r <= 7; r++) begin
      tick(1'b1, (r == 1) || (r == 3));
      n_checks++;
      if (bus_init !== (r <= 5) || obs !== m_out()) begin
        n_fail++;
        $display("FAIL swinit_double rel %0d: got %b expected %b", r, obs, m_out());
      end
    end
  endtask

  task automatic test_powerdown();
    logic [3:0] exp;
    for (int r = 1; r <= 9; r++) begin
      tick(1'b0, 1'b0);
      exp = (r < 7) ? 4'b1000 : 4'b1110;
      n_checks++;
      if (obs !== exp || obs !== m_out()) begin
        n_fail++;
        $display("FAIL powerdown rel %0d: got %b expected %b", r, obs, exp);
      end
    end
  endtask

  task automatic test_early_drop();
    logic exp_dc;
    do_reset(1'b1);
    for (int e = 1; e <= 12; e++) begin
      tick(e != 4, 1'b0);
      n_checks++;
      if (bus_dc_lo !== (e < 10) || obs !== m_out()) begin
        n_fail++;
        $display("FAIL drop_in_dcup edge %0d: got %b expected dc_lo %b", edge_n, obs, e < 10);
      end
    end
    do_reset(1'b1);
    for (int e = 1; e <= 16; e++) begin
      tick(e < 8, 1'b0);
      exp_dc = (e >= 6 && e < 14) ? 1'b0 : 1'b1;
      n_checks++;
      if (bus_dc_lo !== exp_dc || obs !== m_out()) begin
        n_fail++;
        $display("FAIL drop_in_init edge %0d: got %b expected dc_lo %b", edge_n, obs, exp_dc);
      end
    end
  endtask

  task automatic test_pfail_reassert();
    logic exp_dc;
    do_reset(1'b1);
    repeat (14) tick(1'b1, 1'b0);
    for (int r = 1; r <= 22; r++) begin
      tick(!(r == 1 || r == 3), 1'b0);
      exp_dc = (r >= 7 && r < 13);
      n_checks++;
      if (bus_ac_lo !== (r < 21) || pwr_ok !== (r >= 21) || bus_dc_lo !== exp_dc) begin
        n_fail++;
        $display("FAIL pfail_reassert rel %0d: got %b expected ac %b dc %b", r, obs, r < 21, exp_dc);
      end
      n_checks++;
      if (obs !== m_out()) begin
        n_fail++;
        $display("FAIL pfail_model rel %0d: got %b expected %b", r, obs, m_out());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (11) tick(1'b1, 1'b0);
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL acup_before_reset: got %b expected %b", obs, 4'b1000);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 4'b1110) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", obs, 4'b1110);
    end
    m_reset();
  endtask

  task automatic test_random();
    logic pr;
    logic cr;
    do_reset(1'b1);
    pr = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (pr) pr = ($urandom_range(0, 59) != 0);
      else    pr = ($urandom_range(0, 5) == 0);
      cr = ($urandom_range(0, 9) == 0);
      tick(pr, cr);
      n_checks++;
      if (obs !== m_out()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b", i, obs, m_out());
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 4'b1110) begin
          n_fail++;
          $display("FAIL random_reset cycle %0d: got %b expected %b", i, obs, 4'b1110);
        end
        m_reset();
        @(negedge clk);
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_swinit();
    test_powerdown();
    test_early_drop();
    test_pfail_reassert();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
